ex_muldiv_sequencer: RTL and testbench
======================================

# ex_muldiv_sequencer

Multi-cycle multiply/divide sequencer for the EX stage. It takes a multiply or divide request from the EX stage, runs an iterative 32-step unsigned shift-add multiply or restoring divide, and stalls the pipeline until the result is ready. It then returns the result and a 3-bit flag using the same encoding as the EX-stage ALU. This keeps the single-cycle ALU combinational, with MUL/DIV sequenced here.

## Interface
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  request pulse/level; sampled only when state is IDLE or DONE.
- op  input  1  0 = MUL, 1 = DIV; sampled with start.
- flush  input  1  abort the current operation (pipeline squash).
- data_a  input  WIDTH  multiplicand / dividend; sampled with start.
- data_b  input  WIDTH  multiplier / divisor; sampled with start.
- result  output  WIDTH  MUL: low word of the product; DIV: quotient. Registered.
- remainder  output  WIDTH  DIV: remainder; MUL: high word of the product. Registered.
- flag  output  3  000 none, 010 exception (divide by zero), 011 overflow (MUL high word ≠ 0). Registered.
- busy  output  1  high in the MUL and DIV states.
- done  output  1  high for exactly the one cycle spent in DONE.
- stall  output  1  combinational: (start & state∈{IDLE,DONE} & ~flush) | busy.

## Operation
- States: IDLE, MUL, DIV, DONE. Internal 6-bit step counter, 2·WIDTH accumulator, WIDTH operand register.
- IDLE/DONE with start=1, flush=0:
  - Latch the operands and load the counter with WIDTH.
  - Go to MUL or DIV according to op.
  - Exception: DIV with data_b=0 goes directly to DONE with result=0xFFFFFFFF, remainder=data_a, flag=010.
- IDLE/DONE with start=0: IDLE (DONE always leaves after one cycle).
- MUL step:
  - If multiplier bit 0 is set, add the multiplicand to the accumulator upper half.
  - Shift the {carry, acc, multiplier} chain right by 1 and decrement the counter.
  - When the counter reaches 0: result=product[31:0], remainder=product[63:32], flag=011 if product[63:32]≠0 else 000. Go to DONE.
- DIV step (restoring):
  - Shift {rem, quotient} left by 1 and trial-subtract the divisor from rem.
  - If the difference is non-negative (no borrow), keep it and set quotient bit 0; otherwise restore.
  - When the counter reaches 0: result=quotient, remainder=rem, flag=000. Go to DONE.
- All arithmetic is unsigned. The 33-bit intermediate catches the carry/borrow; the product is never truncated before the overflow check.
- result, remainder and flag hold their values until the next completion or reset. They are not cleared on start.
- flush:
  - In any state, the next state is IDLE; done is not asserted.
  - result and flag are left unchanged.
  - flush has priority over start in the same cycle.
- start while busy is ignored; no queueing.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, remainder=0, flag=000, counter=0. stall=0 while reset is high.
- Reset mid-operation aborts immediately at that edge; no done is issued.
- MUL and normal DIV:
  - Start accepted at edge E0.
  - busy is high for cycles after E0 through E32.
  - DONE (done=1, outputs valid) in the cycle after edge E32.
  - Total latency is 33 cycles from start to done.
- DIV by zero: DONE in the cycle after E0 (1 cycle latency); busy never rises.
- stall is high from the start-request cycle through the last MUL/DIV cycle. It is low in DONE, so the pipeline advances and captures result on the same edge.
- Back-to-back: start in the DONE cycle is accepted. done is high for that cycle and busy rises next cycle, with no IDLE bubble.

## Test plan
- MUL 7×6 → done 33 cycles after start; result=42, remainder=0, flag=000; stall high for 33 cycles including the request cycle.
- MUL 0x00010000×0x00010000 → result=0x00000000, remainder=0x00000001, flag=011.
- DIV 100/7 → result=14, remainder=2, flag=000. DIV 0xFFFFFFFF/1 → result=0xFFFFFFFF, remainder=0.
- DIV 5/0 → done 1 cycle after start; result=0xFFFFFFFF, remainder=5, flag=010; busy stays 0.
- Abort checks:
  - MUL started, flush at cycle 10 → IDLE next cycle, no done; result and flag keep their previous values.
  - Repeat the run with reset instead of flush → all outputs at reset values.
- start asserted during busy with different operands → ignored; the original result is delivered. Then start in the DONE cycle → second operation completes 33 cycles later.

Source files
------------

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: iterative unsigned shift-add multiply and
// restoring divide for the EX stage; stalls the pipe until done.
module ex_muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic             flush,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic [2:0]       flag,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_e;

   localparam logic [2:0] FLAG_NONE = 3'b000;
   localparam logic [2:0] FLAG_EXC  = 3'b010;
   localparam logic [2:0] FLAG_OVF  = 3'b011;

   state_e             state_q;
   logic [5:0]         cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   result_q;
   logic [WIDTH-1:0]   rem_q;
   logic [2:0]         flag_q;

   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_d;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ok;
   logic [2*WIDTH-1:0] div_d;
   logic               idle_or_done;
   logic               unused_bits;

   assign hi = acc_q[2*WIDTH-1:WIDTH];
   assign lo = acc_q[WIDTH-1:0];

   // one shift-add step: conditional add into the upper half, then
   // shift the whole {carry, hi, lo} chain right by one
   assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
   assign mul_d   = {mul_sum, lo[WIDTH-1:1]};

   // one restoring step: shift {rem, quo} left, trial-subtract divisor
   assign div_sh   = {hi, lo[WIDTH-1]};
   assign div_ok   = div_sh >= {1'b0, opnd_q};
   assign div_diff = div_sh - {1'b0, opnd_q};
   assign div_d    = div_ok ?
                     {div_diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1} :
                     {div_sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};

   assign unused_bits = ^{div_diff[WIDTH], div_sh[WIDTH]};

   assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);

   assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
   assign done      = (state_q == S_DONE);
   assign result    = result_q;
   assign remainder = rem_q;
   assign flag      = flag_q;
   assign stall     = ~reset &
                      ((start & idle_or_done & ~flush) | busy);

   // sequencer FSM with datapath and registered results
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         result_q <= '0;
         rem_q    <= '0;
         flag_q   <= FLAG_NONE;
      end else if (flush) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (!start) begin
                  state_q <= S_IDLE;
               end else if (op && (data_b == '0)) begin
                  state_q  <= S_DONE;
                  cnt_q    <= '0;
                  result_q <= '1;
                  rem_q    <= data_a;
                  flag_q   <= FLAG_EXC;
               end else begin
                  cnt_q   <= 6'(WIDTH);
                  opnd_q  <= op ? data_b : data_a;
                  acc_q   <= {{WIDTH{1'b0}}, (op ? data_a : data_b)};
                  state_q <= op ? S_DIV : S_MUL;
               end
            end
            S_MUL: begin
               acc_q <= mul_d;
               cnt_q <= cnt_q - 6'd1;
               if (cnt_q == 6'd1) begin
                  state_q  <= S_DONE;
                  result_q <= mul_d[WIDTH-1:0];
                  rem_q    <= mul_d[2*WIDTH-1:WIDTH];
                  flag_q   <= (mul_d[2*WIDTH-1:WIDTH] != '0) ?
                              FLAG_OVF : FLAG_NONE;
               end
            end
            S_DIV: begin
               acc_q <= div_d;
               cnt_q <= cnt_q - 6'd1;
               if (cnt_q == 6'd1) begin
                  state_q  <= S_DONE;
                  result_q <= div_d[WIDTH-1:0];
                  rem_q    <= div_d[2*WIDTH-1:WIDTH];
                  flag_q   <= FLAG_NONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb_ex_muldiv_sequencer: directed vectors for the mul/div sequencer
// with hand-computed results, latency and stall/busy cycle counts.
module tb_ex_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        op;
   logic        flush;
   logic [31:0] data_a;
   logic [31:0] data_b;
   logic [31:0] result;
   logic [31:0] remainder;
   logic [2:0]  flag;
   logic        busy;
   logic        done;
   logic        stall;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ex_muldiv_sequencer #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .flush     (flush),
      .data_a    (data_a),
      .data_b    (data_b),
      .result    (result),
      .remainder (remainder),
      .flag      (flag),
      .busy      (busy),
      .done      (done),
      .stall     (stall)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // issue a request in the current cycle and run until done
   task automatic run_op(input logic o, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output int stl, output int bsy);
      op     = o;
      data_a = a;
      data_b = b;
      start  = 1'b1;
      lat    = 0;
      stl    = 0;
      bsy    = 0;
      do begin
         #1;
         if (stall) stl++;
         if (busy) bsy++;
         tick();
         start = 1'b0;
         lat++;
      end while (!done && lat < 40);
   endtask

   int lat;
   int stl;
   int bsy;

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      op     = 1'b0;
      flush  = 1'b0;
      data_a = '0;
      data_b = '0;
      tick();
      tick();
      check("rst_result", result, 0);
      check("rst_rem", remainder, 0);
      check("rst_flag", flag, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      tick();

      // MUL 7 x 6
      run_op(1'b0, 32'd7, 32'd6, lat, stl, bsy);
      check("mul1_lat", lat, 33);
      check("mul1_stall", stl, 33);
      check("mul1_busy", bsy, 32);
      check("mul1_done", done, 1);
      check("mul1_stall_done", stall, 0);
      check("mul1_result", result, 42);
      check("mul1_rem", remainder, 0);
      check("mul1_flag", flag, 3'b000);
      tick();
      check("mul1_done_drop", done, 0);

      // MUL overflow into high word
      run_op(1'b0, 32'h0001_0000, 32'h0001_0000, lat, stl, bsy);
      check("mul2_lat", lat, 33);
      check("mul2_result", result, 32'h0);
      check("mul2_rem", remainder, 32'h1);
      check("mul2_flag", flag, 3'b011);
      tick();

      // MUL full-width operands
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stl, bsy);
      check("mul3_result", result, 32'h0000_0001);
      check("mul3_rem", remainder, 32'hFFFF_FFFE);
      check("mul3_flag", flag, 3'b011);
      tick();

      // DIV 100 / 7
      run_op(1'b1, 32'd100, 32'd7, lat, stl, bsy);
      check("div1_lat", lat, 33);
      check("div1_busy", bsy, 32);
      check("div1_result", result, 14);
      check("div1_rem", remainder, 2);
      check("div1_flag", flag, 3'b000);
      tick();

      // DIV 0xFFFFFFFF / 1
      run_op(1'b1, 32'hFFFF_FFFF, 32'd1, lat, stl, bsy);
      check("div2_result", result, 32'hFFFF_FFFF);
      check("div2_rem", remainder, 0);
      tick();

      // DIV with divisor above dividend
      run_op(1'b1, 32'd5, 32'hFFFF_FFFF, lat, stl, bsy);
      check("div3_result", result, 0);
      check("div3_rem", remainder, 5);
      tick();

      // DIV 5 / 0
      run_op(1'b1, 32'd5, 32'd0, lat, stl, bsy);
      check("div0_lat", lat, 1);
      check("div0_busy", bsy, 0);
      check("div0_stall", stl, 1);
      check("div0_result", result, 32'hFFFF_FFFF);
      check("div0_rem", remainder, 5);
      check("div0_flag", flag, 3'b010);
      tick();

      // flush mid-MUL: no done, result/flag retained
      op     = 1'b0;
      data_a = 32'h0001_0000;
      data_b = 32'h0001_0000;
      start  = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check("fl_busy_pre", busy, 1);
      flush = 1'b1;
      start = 1'b1;
      #1;
      check("fl_stall", stall, 1);
      tick();
      flush = 1'b0;
      start = 1'b0;
      check("fl_busy", busy, 0);
      check("fl_done", done, 0);
      check("fl_result", result, 32'hFFFF_FFFF);
      check("fl_flag", flag, 3'b010);
      bsy = 0;
      repeat (40) begin
         tick();
         if (done || busy) bsy++;
      end
      check("fl_quiet", bsy, 0);

      // reset mid-MUL: all outputs back to reset values
      op     = 1'b0;
      data_a = 32'd9;
      data_b = 32'd9;
      start  = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      reset = 1'b1;
      start = 1'b1;
      #1;
      check("rs_stall", stall, 0);
      tick();
      reset = 1'b0;
      start = 1'b0;
      check("rs_result", result, 0);
      check("rs_rem", remainder, 0);
      check("rs_flag", flag, 0);
      check("rs_busy", busy, 0);
      check("rs_done", done, 0);
      tick();
      check("rs_idle", busy | done, 0);

      // start while busy ignored, then back-to-back from DONE
      op     = 1'b0;
      data_a = 32'd7;
      data_b = 32'd6;
      start  = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      op     = 1'b1;
      data_a = 32'd100;
      data_b = 32'd7;
      start  = 1'b1;
      tick();
      start = 1'b0;
      lat = 6;
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
      check("bb_lat1", lat, 33);
      check("bb_result1", result, 42);
      check("bb_flag1", flag, 0);
      run_op(1'b1, 32'd100, 32'd7, lat, stl, bsy);
      check("bb_lat2", lat, 33);
      check("bb_busy2", bsy, 32);
      check("bb_result2", result, 14);
      check("bb_rem2", remainder, 2);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
